gbc_gamepak_responder: RTL and testbench



---
 rtl/gbc_gamepak_pkg.sv | 46 ++++
 rtl/gbc_gamepak_phi_gen.sv | 34 +++
 rtl/gbc_gamepak_responder.sv | 153 +++++++++++++++
 tb/tb_gbc_gamepak_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/gbc_gamepak_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gbc_gamepak_pkg
// Purpose  : Shared types, address map and pin constants for the GamePak
//            cartridge-port responder.
// Revision : 1.0 - initial release
// ============================================================================
package gbc_gamepak_pkg;

  // Bus-cycle sequencer states
  typedef enum logic [2:0] {
    CART_RESET = 3'd0,
    IDLE       = 3'd1,
    SETUP      = 3'd2,
    STROBE     = 3'd3,
    HOLD       = 3'd4
  } state_t;

  // Address map (ROM spans 0x0000 up to ROM_HI)
  localparam logic [15:0] ROM_HI      = 16'h7FFF;
  localparam logic [15:0] VRAM_LO     = 16'h8000;
  localparam logic [15:0] VRAM_HI     = 16'h9FFF;
  localparam logic [15:0] CS_LO       = 16'hA000;
  localparam logic [15:0] CS_HI       = 16'hFDFF;
  localparam logic [15:0] INTERNAL_LO = 16'hFE00;

  // Idle level of the active-low cartridge strobes, and open-bus read value
  localparam logic       PIN_IDLE = 1'b1;
  localparam logic [7:0] OPEN_BUS = 8'hFF;

  // Cartridge RAM / external range that asserts the CS pin
  function automatic logic is_cs_range(input logic [15:0] addr);
    return (addr >= CS_LO) && (addr <= CS_HI);
  endfunction

  // Any address that results in a physical pin cycle
  function automatic logic is_cart_access(input logic [15:0] addr);
    logic in_vram;
    logic in_internal;
    in_vram     = (addr >= VRAM_LO) && (addr <= VRAM_HI);
    in_internal = (addr >= INTERNAL_LO);
    return (addr <= ROM_HI) || (!in_vram && !in_internal && is_cs_range(addr));
  endfunction

endpackage
`default_nettype wire

// File: rtl/gbc_gamepak_phi_gen.sv
`default_nettype none
// ============================================================================
// Module   : gbc_gamepak_phi_gen
// Purpose  : Free-running divider producing the cartridge PHI clock.
// Revision : 1.0 - initial release
// ============================================================================
module gbc_gamepak_phi_gen #(
  parameter int PhiHalfPeriod = 100
) (
  input  logic Clk,
  input  logic Reset,
  output logic CartClk
);

  localparam int            CW   = (PhiHalfPeriod > 1) ? $clog2(PhiHalfPeriod) : 1;
  localparam logic [CW-1:0] LAST = CW'(PhiHalfPeriod - 1);

  logic [CW-1:0] div_cnt;

  // Toggle PHI every PhiHalfPeriod core cycles, independent of bus activity
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_cnt <= '0;
      CartClk <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      CartClk <= ~CartClk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/gbc_gamepak_responder.sv
`default_nettype none
// ============================================================================
// Module   : gbc_gamepak_responder
// Purpose  : Executes single-byte core memory requests as timed GamePak pin
//            cycles, holding Ready/DataReady low until each cycle completes.
// Revision : 1.0 - initial release
// ============================================================================
module gbc_gamepak_responder
  import gbc_gamepak_pkg::*;
#(
  parameter int SetupCycles   = 2,
  parameter int StrobeCycles  = 4,
  parameter int HoldCycles    = 1,
  parameter int ResetCycles   = 16,
  parameter int PhiHalfPeriod = 100
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Access,
  input  logic        Write,
  input  logic [15:0] Address,
  input  logic [7:0]  DInitiator,
  output logic [7:0]  DTarget,
  output logic        Ready,
  output logic        DataReady,
  output logic        CartClk,
  output logic        CartRead,
  output logic        CartWrite,
  output logic        CartCS,
  output logic        CartReset,
  output logic [15:0] CartAddress,
  output logic [7:0]  CartDataOut,
  output logic        CartDataOE,
  input  logic [7:0]  CartDataIn,
  input  logic        CartAudioIn,
  output logic        AudioOut
);

  localparam int MAX_A   = (SetupCycles > StrobeCycles) ? SetupCycles : StrobeCycles;
  localparam int MAX_B   = (HoldCycles > ResetCycles) ? HoldCycles : ResetCycles;
  localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] SETUP_LAST  = CW'(SetupCycles - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(StrobeCycles - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HoldCycles - 1);
  // CART_RESET runs one cycle past the pulse so Ready rises after CartReset releases
  localparam logic [CW-1:0] RESET_LAST  = CW'(ResetCycles);

  state_t        state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [15:0]   lat_addr;
  logic          lat_write;
  logic [7:0]    lat_data;
  logic          accept, accept_cart, busy_next, write_next, sample_read;
  logic [15:0]   addr_next;
  logic [7:0]    data_next;
  logic          audio_meta;

  gbc_gamepak_phi_gen #(
    .PhiHalfPeriod(PhiHalfPeriod)
  ) u_phi_gen (
    .Clk    (Clk),
    .Reset  (Reset),
    .CartClk(CartClk)
  );

  // Request acceptance and the request fields that apply in the next cycle
  always_comb begin
    accept      = (state == IDLE) && Access && Ready;
    accept_cart = accept && is_cart_access(Address);
    addr_next   = accept ? Address    : lat_addr;
    write_next  = accept ? Write      : lat_write;
    data_next   = accept ? DInitiator : lat_data;
  end

  // Next-state and phase-counter logic; counter reloads on every state entry
  always_comb begin
    state_next  = state;
    cnt_next    = cnt + CW'(1);
    sample_read = 1'b0;
    case (state)
      CART_RESET: if (cnt == RESET_LAST) begin state_next = IDLE; cnt_next = '0; end
      IDLE: begin
        cnt_next = '0;
        if (accept_cart) state_next = SETUP;
      end
      SETUP: if (cnt == SETUP_LAST) begin state_next = STROBE; cnt_next = '0; end
      STROBE: if (cnt == STROBE_LAST) begin
        state_next  = HOLD;
        cnt_next    = '0;
        sample_read = !lat_write;
      end
      HOLD: if (cnt == HOLD_LAST) begin state_next = IDLE; cnt_next = '0; end
      default: begin state_next = CART_RESET; cnt_next = '0; end
    endcase
    busy_next = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);
  end

  // State register and registered outputs, all derived from next-cycle values
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= CART_RESET;
      cnt         <= '0;
      lat_addr    <= '0;
      lat_write   <= 1'b0;
      lat_data    <= '0;
      Ready       <= 1'b0;
      DataReady   <= 1'b0;
      DTarget     <= OPEN_BUS;
      CartRead    <= PIN_IDLE;
      CartWrite   <= PIN_IDLE;
      CartCS      <= PIN_IDLE;
      CartReset   <= ~PIN_IDLE;
      CartAddress <= '0;
      CartDataOE  <= 1'b0;
      CartDataOut <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_addr  <= Address;
        lat_write <= Write;
        lat_data  <= DInitiator;
      end
      Ready <= (state_next == IDLE) && !accept;
      if (accept) DataReady <= Write;
      else if (state_next == IDLE) DataReady <= 1'b1;
      if (accept && !accept_cart && !Write) DTarget <= OPEN_BUS;
      else if (sample_read) DTarget <= CartDataIn;
      if (accept_cart) CartAddress <= Address;
      CartCS     <= !(busy_next && is_cs_range(addr_next));
      CartRead   <= !((state_next == STROBE) && !write_next);
      CartWrite  <= !((state_next == STROBE) && write_next);
      CartDataOE <= busy_next && write_next;
      if (busy_next && write_next) CartDataOut <= data_next;
      CartReset  <= !((state_next == CART_RESET) && (cnt_next < RESET_LAST));
    end
  end

  // Two-flop synchronizer for the asynchronous cartridge audio input
  always_ff @(posedge Clk) begin
    if (Reset) begin
      audio_meta <= 1'b0;
      AudioOut   <= 1'b0;
    end else begin
      audio_meta <= CartAudioIn;
      AudioOut   <= audio_meta;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gbc_gamepak_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gbc_gamepak_responder
// Purpose  : Self-checking bench for the GamePak responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gbc_gamepak_responder;

  localparam int S   = 2;
  localparam int T   = 4;
  localparam int H   = 1;
  localparam int RC  = 16;
  localparam int PHI = 100;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Access = 1'b0;
  logic        Write = 1'b0;
  logic [15:0] Address = '0;
  logic [7:0]  DInitiator = '0;
  logic [7:0]  CartDataIn = '0;
  logic        CartAudioIn = 1'b0;
  logic [7:0]  DTarget;
  logic        Ready, DataReady, CartClk, CartRead, CartWrite, CartCS, CartReset;
  logic [15:0] CartAddress;
  logic [7:0]  CartDataOut;
  logic        CartDataOE, AudioOut;

  gbc_gamepak_responder #(
    .SetupCycles(S), .StrobeCycles(T), .HoldCycles(H),
    .ResetCycles(RC), .PhiHalfPeriod(PHI)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Access(Access), .Write(Write), .Address(Address),
    .DInitiator(DInitiator), .DTarget(DTarget), .Ready(Ready), .DataReady(DataReady),
    .CartClk(CartClk), .CartRead(CartRead), .CartWrite(CartWrite), .CartCS(CartCS),
    .CartReset(CartReset), .CartAddress(CartAddress), .CartDataOut(CartDataOut),
    .CartDataOE(CartDataOE), .CartDataIn(CartDataIn), .CartAudioIn(CartAudioIn),
    .AudioOut(AudioOut)
  );

  always #5 Clk = ~Clk;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] sb_q[$];
  logic [7:0] model_dt = 8'hFF;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  cart_in;
    logic        exp_pin;
    logic        exp_cs;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] win(input int f, input int l, input int n);
    return {f[7:0], l[7:0], n[7:0]};
  endfunction

  // Called in the first cycle with Reset low; checks reset values then the pulse
  task automatic reset_seq();
    int n_low, last_low, rdy_at, strobe_low;
    chk("rst_ready", Ready, 0);
    chk("rst_dataready", DataReady, 0);
    chk("rst_dtarget", DTarget, 8'hFF);
    chk("rst_pins", {CartRead, CartWrite, CartCS, CartReset}, 4'b1110);
    chk("rst_addr", CartAddress, 16'h0000);
    chk("rst_data", {CartDataOE, CartDataOut}, 9'h000);
    chk("rst_clk_audio", {CartClk, AudioOut}, 2'b00);
    n_low = 0; last_low = -1; rdy_at = -1; strobe_low = 0;
    for (int k = 0; k <= 40 && rdy_at < 0; k++) begin
      if (k > 0) tick();
      if (CartReset === 1'b0) begin n_low++; last_low = k; end
      if ({CartRead, CartWrite, CartCS} !== 3'b111) strobe_low++;
      if (Ready === 1'b1) begin
        rdy_at = k;
        chk("rst_dataready_rise", DataReady, 1);
      end
    end
    chk("rst_pulse_len", n_low, RC);
    chk("rst_pulse_last", last_low, RC - 1);
    chk("rst_strobes_idle", strobe_low, 0);
    chk("rst_ready_at", rdy_at, RC + 1);
    model_dt = 8'hFF;
  endtask

  // Issues one request in the current (Ready=1) cycle and monitors it
  task automatic run_vec(input vec_t v, input bit poke_busy);
    int f_rd = 0, l_rd = 0, n_rd = 0, f_wr = 0, l_wr = 0, n_wr = 0;
    int f_oe = 0, l_oe = 0, n_oe = 0, f_cs = 0, l_cs = 0, n_cs = 0;
    int dr_low = 0, rdy_at = 0;
    logic [7:0] exp_dt;
    int done_c;
    chk("ready_before", Ready, 1);
    Access = 1'b1; Write = v.wr; Address = v.addr;
    DInitiator = v.wdata; CartDataIn = v.cart_in;
    exp_dt = v.wr ? model_dt : v.exp_rd;
    sb_q.push_back(exp_dt);
    model_dt = exp_dt;
    for (int k = 1; k <= 20 && rdy_at == 0; k++) begin
      tick();
      Access = poke_busy && (k == 2);
      if (poke_busy && k == 2) begin Write = 1'b1; Address = 16'h0000; end
      if (CartRead === 1'b0) begin if (f_rd == 0) f_rd = k; l_rd = k; n_rd++; end
      if (CartWrite === 1'b0) begin if (f_wr == 0) f_wr = k; l_wr = k; n_wr++; end
      if (CartDataOE === 1'b1) begin if (f_oe == 0) f_oe = k; l_oe = k; n_oe++; end
      if (CartCS === 1'b0) begin if (f_cs == 0) f_cs = k; l_cs = k; n_cs++; end
      if (DataReady !== 1'b1) dr_low++;
      if (k == 1 && v.exp_pin && v.wr) chk("wdata_out", CartDataOut, v.wdata);
      if (Ready === 1'b1) rdy_at = k;
    end
    Access = 1'b0;
    done_c = v.exp_pin ? (S + T + H + 1) : 2;
    chk("ready_at", rdy_at, done_c);
    chk("read_window", win(f_rd, l_rd, n_rd),
        (v.exp_pin && !v.wr) ? win(S + 1, S + T, T) : 24'h0);
    chk("write_window", win(f_wr, l_wr, n_wr),
        (v.exp_pin && v.wr) ? win(S + 1, S + T, T) : 24'h0);
    chk("oe_window", win(f_oe, l_oe, n_oe),
        (v.exp_pin && v.wr) ? win(1, S + T + H, S + T + H) : 24'h0);
    chk("cs_window", win(f_cs, l_cs, n_cs),
        v.exp_cs ? win(1, S + T + H, S + T + H) : 24'h0);
    chk("dataready_low", dr_low, v.wr ? 0 : done_c - 1);
    chk("dataready_done", DataReady, 1);
    if (sb_q.size() == 0) chk("sb_empty", 1, 0);
    else chk("dtarget", DTarget, sb_q.pop_front());
    if (v.exp_pin) chk("cart_addr", CartAddress, v.addr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad, t0, half;
    logic prev;
    //            wr    addr      wdata  cart_in pin   cs    exp_rd
    vecs[0]  = '{1'b0, 16'h0150, 8'h00, 8'h3E, 1'b1, 1'b0, 8'h3E};
    vecs[1]  = '{1'b1, 16'h2000, 8'h05, 8'hE7, 1'b1, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 16'hA123, 8'h00, 8'h9C, 1'b1, 1'b1, 8'h9C};
    vecs[3]  = '{1'b0, 16'h8800, 8'h00, 8'h5A, 1'b0, 1'b0, 8'hFF};
    vecs[4]  = '{1'b0, 16'hFF44, 8'h00, 8'h5A, 1'b0, 1'b0, 8'hFF};
    vecs[5]  = '{1'b1, 16'hC000, 8'h77, 8'h12, 1'b1, 1'b1, 8'h00};
    vecs[6]  = '{1'b0, 16'h7FFF, 8'h00, 8'h11, 1'b1, 1'b0, 8'h11};
    vecs[7]  = '{1'b0, 16'h9FFF, 8'h00, 8'h66, 1'b0, 1'b0, 8'hFF};
    vecs[8]  = '{1'b0, 16'hFDFF, 8'h00, 8'h22, 1'b1, 1'b1, 8'h22};
    vecs[9]  = '{1'b0, 16'hFE00, 8'h00, 8'h33, 1'b0, 1'b0, 8'hFF};
    vecs[10] = '{1'b1, 16'h8000, 8'hAB, 8'h44, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{1'b0, 16'hA000, 8'h00, 8'hC4, 1'b1, 1'b1, 8'hC4};

    // Reset held for three cycles, then the cartridge reset pulse
    tick(); tick(); tick();
    Reset = 1'b0;
    reset_seq();

    // Table of back-to-back requests
    for (int i = 0; i < 12; i++) run_vec(vecs[i], 1'b0);

    // Access pulsed while busy must be ignored and not queued
    run_vec(vecs[0], 1'b1);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (Ready !== 1'b1 || CartWrite !== 1'b1 || CartDataOE !== 1'b0) bad++;
    end
    chk("busy_access_ignored", bad, 0);

    // Audio synchronizer latency
    CartAudioIn = 1'b1;
    tick();
    chk("audio_stage1", AudioOut, 0);
    tick();
    chk("audio_stage2", AudioOut, 1);
    CartAudioIn = 1'b0;

    // PHI half period
    prev = CartClk;
    t0 = -1;
    for (int k = 0; k < 2 * PHI + 5 && t0 < 0; k++) begin
      tick();
      if (CartClk !== prev) t0 = k;
    end
    prev = CartClk;
    half = -1;
    for (int k = 1; k < 2 * PHI + 5 && half < 0 && t0 >= 0; k++) begin
      tick();
      if (CartClk !== prev) half = k;
    end
    chk("phi_half_period", half, PHI);

    // Reset asserted during the strobe of a write aborts the cycle
    tick();
    chk("ready_before_abort", Ready, 1);
    Access = 1'b1; Write = 1'b1; Address = 16'h2000; DInitiator = 8'h05;
    tick();
    Access = 1'b0;
    tick(); tick(); tick();
    chk("abort_strobe_active", {CartWrite, CartDataOE}, 2'b01);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("abort_strobe_released", {CartWrite, CartDataOE}, 2'b10);
    reset_seq();

    // Reset and Access together: the request is dropped
    Reset = 1'b1; Access = 1'b1; Write = 1'b0; Address = 16'h0150;
    tick();
    Reset = 1'b0; Access = 1'b0;
    reset_seq();
    chk("dropped_addr", CartAddress, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
